// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin sharing of one APB master_bridge among NREQ requesters,
// one transfer in flight. Optional WAIT watchdog is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int TMO_CYC = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_write,
  input  logic [NREQ*ADDR_W-1:0]    req_addr,
  input  logic [NREQ*DATA_W-1:0]    req_wdata,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      transfer,
  output logic                      READ_WRITE,
  output logic [ADDR_W-1:0]         apb_write_paddr,
  output logic [ADDR_W-1:0]         apb_read_paddr,
  output logic [DATA_W-1:0]         apb_write_data,
  input  logic                      PENABLE,
  input  logic                      PREADY,
  input  logic                      PSLVRR,
  input  logic [DATA_W-1:0]         apb_read_data_out
);

  // state  | meaning
  // IDLE   | no transfer in flight; grant the next valid requester after r_rr_ptr
  // ISSUE  | transfer pulse to the bridge, command outputs loaded
  // WAIT   | bridge in SETUP/ENABLE; wait for completion or PSLVRR (or watchdog)
  // RESP   | one-cycle response to the granted requester, then release command
  localparam int ID_W = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  logic                r_run;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_gnt;
  logic                r_cmd_write;
  logic                r_err;
  logic                r_rsp_valid;
  logic                r_transfer;
  logic                r_read_write;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_gnt_found;
  logic [ID_W-1:0]     w_gnt_idx;
  logic                w_sel_write;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

`ifdef APB_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
  logic [7:0]          r_wait_cnt;
  logic                w_tmo;
  assign w_tmo = (r_wait_cnt == TMO_LAST);
`endif

  // Round-robin search: first valid index strictly after r_rr_ptr, with wrap.
  always_comb begin : grant_search
    int cand;
    cand        = 0;
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(r_rr_ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!w_gnt_found && req_valid[cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = ID_W'(cand);
      end
    end
  end

  always_comb begin : cmd_mux
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (ID_W'(k) == w_gnt_idx) begin
        w_sel_write = req_write[k];
        w_sel_addr  = req_addr[k*ADDR_W +: ADDR_W];
        w_sel_wdata = req_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // Accept is combinational so the handshake completes in the IDLE cycle; r_run keeps
  // it low while reset is asserted and in the first cycle after release.
  assign req_ready = (r_state == S_IDLE && r_run && w_gnt_found) ?
                     (NREQ'(1) << w_gnt_idx) : '0;

  assign transfer        = r_transfer;
  assign READ_WRITE      = r_read_write;
  assign apb_write_paddr = r_paddr;
  assign apb_read_paddr  = r_paddr;
  assign apb_write_data  = r_wdata;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_id          = r_rsp_valid ? r_gnt : '0;
  assign rsp_err         = r_rsp_valid & r_err;
  // The bridge only updates its read data on the completion edge, so pass it through in RESP.
  assign rsp_rdata       = (r_rsp_valid && !r_cmd_write && !r_err) ? apb_read_data_out : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state      <= S_IDLE;
      r_run        <= 1'b0;
      r_rr_ptr     <= ID_W'(NREQ - 1);
      r_gnt        <= '0;
      r_cmd_write  <= 1'b0;
      r_err        <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_transfer   <= 1'b0;
      r_read_write <= 1'b0;
      r_paddr      <= '0;
      r_wdata      <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      r_wait_cnt   <= '0;
`endif
    end else begin
      r_run <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_rsp_valid <= 1'b0;
          if (r_run && w_gnt_found) begin
            r_gnt        <= w_gnt_idx;
            r_rr_ptr     <= w_gnt_idx;
            r_cmd_write  <= w_sel_write;
            r_read_write <= ~w_sel_write;
            r_paddr      <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_err        <= 1'b0;
            r_transfer   <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_transfer <= 1'b0;
          r_state    <= S_WAIT;
`ifdef APB_ARB_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (PSLVRR) begin
            r_err       <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (PENABLE && PREADY) begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
`ifdef APB_ARB_TIMEOUT_EN
          end else if (w_tmo) begin
            r_err       <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_wait_cnt  <= r_wait_cnt + 8'd1;
`endif
          end
        end
        S_RESP: begin
          r_rsp_valid  <= 1'b0;
          r_err        <= 1'b0;
          r_read_write <= 1'b0;
          r_paddr      <= '0;
          r_wdata      <= '0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_transfer  <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed bench for apb_req_arbiter with a small behavioural bridge/slave.
// Timeout expectations follow APB_ARB_TIMEOUT_EN as seen by this compile.
`timescale 1ns/1ps
module tb_apb_req_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 9;
  localparam int DW   = 8;

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic [NREQ-1:0]   req_valid, req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  wire  [NREQ-1:0]   req_ready;
  wire               rsp_valid, rsp_err, transfer, READ_WRITE;
  wire  [1:0]        rsp_id;
  wire  [DW-1:0]     rsp_rdata, apb_write_data;
  wire  [AW-1:0]     apb_write_paddr, apb_read_paddr;
  wire               PENABLE, PREADY, PSLVRR;
  logic [DW-1:0]     apb_read_data_out;

  apb_req_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TMO_CYC(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .transfer(transfer), .READ_WRITE(READ_WRITE),
    .apb_write_paddr(apb_write_paddr), .apb_read_paddr(apb_read_paddr),
    .apb_write_data(apb_write_data), .PENABLE(PENABLE), .PREADY(PREADY), .PSLVRR(PSLVRR),
    .apb_read_data_out(apb_read_data_out)
  );

  always #5 PCLK = ~PCLK;

  // Bridge model: IDLE(0) -> SETUP(1) -> ACCESS(2), completes in ACCESS when PREADY.
  int          b_state;
  int          acc_cnt;
  logic        b_rd;
  logic        tb_hold, tb_inj;
  int          tb_waits;
  logic [7:0]  slave_rdata;

  assign PENABLE = (b_state == 2);
  assign PREADY  = (b_state == 2) && !tb_hold && (acc_cnt >= tb_waits);
  assign PSLVRR  = tb_inj && PREADY;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      b_state <= 0; acc_cnt <= 0; b_rd <= 1'b0; apb_read_data_out <= '0;
    end else begin
      case (b_state)
        0: if (transfer) begin b_state <= 1; b_rd <= READ_WRITE; end
        1: begin b_state <= 2; acc_cnt <= 0; end
        default: if (PREADY) begin
                   b_state <= 0;
                   if (b_rd) apb_read_data_out <= slave_rdata;
                 end else acc_cnt <= acc_cnt + 1;
      endcase
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int rsp_cnt = 0;

  always @(negedge PCLK) if (rsp_valid === 1'b1) rsp_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag, input int idx);
    bit seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge PCLK);
      if (req_ready[idx]) seen = 1;
    end
    chk({tag, "_ready_seen"}, seen, 1);
    chk({tag, "_ready_onehot"}, req_ready, 4'b0001 << idx);
  endtask

  task automatic run_req(input string tag, input int idx, input logic wr, input logic [8:0] addr,
                         input logic [7:0] wd, input int waits, input logic inj,
                         input logic [7:0] srd, input int exp_lat, input logic [7:0] exp_rd,
                         input logic exp_err);
    int lat;
    bit seen;
    tb_waits = waits; tb_inj = inj; slave_rdata = srd;
    req_write[idx] = wr;
    req_addr[idx*AW +: AW] = addr;
    req_wdata[idx*DW +: DW] = wd;
    req_valid[idx] = 1'b1;
    wait_ready(tag, idx);
    @(posedge PCLK); #1 req_valid[idx] = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 60) begin
      @(negedge PCLK); lat++;
      if (lat == 1) begin
        chk({tag, "_transfer"}, transfer, 1);
        chk({tag, "_read_write"}, READ_WRITE, !wr);
        chk({tag, "_wpaddr"}, apb_write_paddr, addr);
        chk({tag, "_rpaddr"}, apb_read_paddr, addr);
        chk({tag, "_wdata"}, apb_write_data, wd);
      end
      if (lat == 2) chk({tag, "_transfer_drop"}, transfer, 0);
      if (rsp_valid) seen = 1;
    end
    chk({tag, "_rsp_seen"}, seen, 1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_rsp_id"}, rsp_id, idx);
    chk({tag, "_rsp_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_rsp_err"}, rsp_err, exp_err);
    chk({tag, "_addr_held"}, apb_write_paddr, addr);
    @(posedge PCLK); #1 tb_inj = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge PCLK);
      if (rsp_valid) seen = 1;
    end
    chk({tag, "_drain"}, seen, 1);
    @(posedge PCLK); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, g, lat, cnt0;
    bit seen;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    tb_hold = 0; tb_inj = 0; tb_waits = 0; slave_rdata = '0;

    // Reset state, with requests pending to show accept is held off
    req_valid = 4'hF;
    repeat (2) @(negedge PCLK);
    chk("rst_outputs", {req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, transfer, READ_WRITE,
                        apb_write_paddr, apb_read_paddr, apb_write_data}, 0);
    req_valid = '0;
    @(posedge PCLK); #1 PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);
    chk("idle_outputs", {req_ready, rsp_valid, transfer, READ_WRITE, apb_write_paddr}, 0);

    // Fairness: all four valid, eight grants
    @(posedge PCLK); #1;
    for (int i = 0; i < NREQ; i++) begin
      req_write[i] = 1'b1;
      req_addr[i*AW +: AW] = 9'(9'h020 + i);
      req_wdata[i*DW +: DW] = 8'(8'h10 + i);
    end
    tb_waits = 0;
    req_valid = 4'hF;
    k = 0;
    for (int c = 0; c < 200 && k < 8; c++) begin
      @(negedge PCLK);
      if (req_ready != '0) begin
        g = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
        chk("fair_grant", g, k % 4);
        chk("fair_onehot", $onehot(req_ready), 1);
        k++;
      end
    end
    chk("fair_count", k, 8);
    @(posedge PCLK); #1 req_valid = '0;
    drain("fair");

    // Single write, read with wait states, error, recovery, write ignores bus data
    run_req("wr0", 0, 1'b1, 9'h012, 8'hA5, 0, 1'b0, 8'h00, 4, 8'h00, 1'b0);
    run_req("rd2", 2, 1'b0, 9'h1F0, 8'h00, 2, 1'b0, 8'h3C, 6, 8'h3C, 1'b0);
    run_req("err3", 3, 1'b0, 9'h044, 8'h00, 1, 1'b1, 8'h77, 5, 8'h00, 1'b1);
    run_req("after_err", 1, 1'b0, 9'h105, 8'h00, 0, 1'b0, 8'h5A, 4, 8'h5A, 1'b0);
    run_req("wr_zero", 2, 1'b1, 9'h1AA, 8'h3E, 0, 1'b0, 8'hFF, 4, 8'h00, 1'b0);

    // Slave never ready
    tb_hold = 1; tb_waits = 0; slave_rdata = 8'h99;
    req_write[1] = 1'b0; req_addr[1*AW +: AW] = 9'h0C3; req_valid[1] = 1'b1;
    wait_ready("tmo", 1);
    @(posedge PCLK); #1 req_valid[1] = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    lat = 0; seen = 0;
    while (!seen && lat < 60) begin
      @(negedge PCLK); lat++;
      if (rsp_valid) seen = 1;
    end
    chk("tmo_seen", seen, 1);
    chk("tmo_latency", lat, 18);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_rdata", rsp_rdata, 0);
    @(posedge PCLK); #1 tb_hold = 0;
    repeat (3) @(negedge PCLK);
`else
    cnt0 = rsp_cnt;
    repeat (100) @(negedge PCLK);
    chk("no_tmo_rsp", rsp_cnt - cnt0, 0);
    tb_hold = 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge PCLK);
      if (rsp_valid) seen = 1;
    end
    chk("late_seen", seen, 1);
    chk("late_err", rsp_err, 0);
    chk("late_rdata", rsp_rdata, 8'h99);
`endif
    @(posedge PCLK); #1;

    // Reset mid-WAIT
    tb_hold = 1; slave_rdata = 8'h42;
    req_write[1] = 1'b0; req_addr[1*AW +: AW] = 9'h1C7; req_valid[1] = 1'b1;
    wait_ready("rstw", 1);
    @(posedge PCLK); #1 req_valid[1] = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("rstw_loaded", {READ_WRITE, apb_read_paddr}, {1'b1, 9'h1C7});
    PRESETn = 1'b0;
    #1;
    chk("rstw_outputs", {req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, transfer, READ_WRITE,
                         apb_write_paddr, apb_read_paddr, apb_write_data}, 0);
    tb_hold = 0;
    cnt0 = rsp_cnt;
    @(negedge PCLK); PRESETn = 1'b1;
    repeat (10) @(negedge PCLK);
    chk("rstw_no_rsp", rsp_cnt - cnt0, 0);
    @(posedge PCLK); #1;
    req_write[0] = 1'b0; req_addr[0*AW +: AW] = 9'h003;
    req_write[2] = 1'b0; req_addr[2*AW +: AW] = 9'h103;
    req_valid = 4'b0101;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge PCLK);
      if (req_ready != '0) seen = 1;
    end
    chk("rstw_next_grant", req_ready, 4'b0001);
    @(posedge PCLK); #1 req_valid = '0;
    drain("rstw_next");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
